// File: rtl/ucsbece154b_pkg.sv
// Shared constants and types for the RV32I teaching SoC: memory map defaults, NOP,
// opcode map, and the decoded control word passed from decode into the datapath.
package ucsbece154b_pkg;

  localparam logic [31:0] TextBaseDefault = 32'h0001_0000;
  localparam logic [31:0] DataBaseDefault = 32'h1000_0000;
  localparam logic [31:0] NopInstr        = 32'h0000_0013;

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;

  typedef enum logic [3:0] {
    AluAdd, AluSub, AluSll, AluSlt, AluSltu, AluXor,
    AluSrl, AluSra, AluOr, AluAnd, AluPassB
  } alu_op_e;

  typedef enum logic [1:0] {WbAlu, WbMem, WbPc4} wb_sel_e;

  typedef enum logic [2:0] {ImmI, ImmS, ImmB, ImmU, ImmJ} imm_sel_e;

  typedef struct packed {
    logic     reg_we;
    logic     mem_we;
    logic     alu_src_imm;
    logic     alu_a_pc;
    logic     branch;
    logic     jump;
    logic     jalr;
    alu_op_e  alu_op;
    wb_sel_e  wb_sel;
    imm_sel_e imm_sel;
  } ctrl_t;

  // alt selects SUB/SRA; callers must only set it where funct7[5] is meaningful.
  function automatic alu_op_e alu_fn(input logic [2:0] funct3, input logic alt);
    case (funct3)
      3'b000:  return alt ? AluSub : AluAdd;
      3'b001:  return AluSll;
      3'b010:  return AluSlt;
      3'b011:  return AluSltu;
      3'b100:  return AluXor;
      3'b101:  return alt ? AluSra : AluSrl;
      3'b110:  return AluOr;
      default: return AluAnd;
    endcase
  endfunction

endpackage

// File: rtl/ucsbece154b_if.sv
// Flat 32-bit word memory bus: one read/write port (a) plus one extra read port (b).
interface ucsbece154b_if;
  logic [31:0] addr;
  logic [31:0] addr_b;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] rdata;
  logic [31:0] rdata_b;

  modport master (output addr, addr_b, wdata, we, input rdata, rdata_b);
  modport slave  (input addr, addr_b, wdata, we, output rdata, rdata_b);
endinterface

// File: rtl/ucsbece154b_datapath.sv
// Single-cycle RV32I datapath: PC, immediate generation, ALU, branch compare, writeback.
module ucsbece154b_datapath
  import ucsbece154b_pkg::*;
#(
  parameter logic [31:0] ResetPc = TextBaseDefault
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] instr_i,
  input  ctrl_t       ctrl_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] alu_o,
  output logic [31:0] wdata_o
);

  logic [31:0] pc_q, pc_d, pc4, imm, rs1_val, rs2_val, op_a, op_b, alu, wb;
  logic        take;
  logic        unused_opcode;

  assign unused_opcode = ^instr_i[6:0];

  always_comb begin
    imm = '0;
    case (ctrl_i.imm_sel)
      ImmI:    imm = {{20{instr_i[31]}}, instr_i[31:20]};
      ImmS:    imm = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      ImmB:    imm = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                      instr_i[11:8], 1'b0};
      ImmU:    imm = {instr_i[31:12], 12'b0};
      ImmJ:    imm = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                      instr_i[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

  assign op_a = ctrl_i.alu_a_pc ? pc_q : rs1_val;
  assign op_b = ctrl_i.alu_src_imm ? imm : rs2_val;

  always_comb begin
    alu = '0;
    case (ctrl_i.alu_op)
      AluAdd:   alu = op_a + op_b;
      AluSub:   alu = op_a - op_b;
      AluSll:   alu = op_a << op_b[4:0];
      AluSlt:   alu = {31'b0, $signed(op_a) < $signed(op_b)};
      AluSltu:  alu = {31'b0, op_a < op_b};
      AluXor:   alu = op_a ^ op_b;
      AluSrl:   alu = op_a >> op_b[4:0];
      AluSra:   alu = $unsigned($signed(op_a) >>> op_b[4:0]);
      AluOr:    alu = op_a | op_b;
      AluAnd:   alu = op_a & op_b;
      AluPassB: alu = op_b;
      default:  alu = '0;
    endcase
  end

  always_comb begin
    take = 1'b0;
    case (instr_i[14:12])
      3'b000:  take = (rs1_val == rs2_val);
      3'b001:  take = (rs1_val != rs2_val);
      3'b100:  take = ($signed(rs1_val) < $signed(rs2_val));
      3'b101:  take = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110:  take = (rs1_val < rs2_val);
      3'b111:  take = (rs1_val >= rs2_val);
      default: take = 1'b0;
    endcase
  end

  assign pc4 = pc_q + 32'd4;

  always_comb begin
    pc_d = pc4;
    if (ctrl_i.jump || (ctrl_i.branch && take)) pc_d = pc_q + imm;
    else if (ctrl_i.jalr)                       pc_d = alu & ~32'd1;
  end

  always_comb begin
    wb = alu;
    case (ctrl_i.wb_sel)
      WbMem:   wb = rdata_i;
      WbPc4:   wb = pc4;
      default: wb = alu;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) pc_q <= ResetPc;
    else         pc_q <= pc_d;
  end

  ucsbece154b_rf rf (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .rs1_i (instr_i[19:15]),
    .rs2_i (instr_i[24:20]),
    .rd_i  (instr_i[11:7]),
    .we_i  (ctrl_i.reg_we),
    .wd_i  (wb),
    .rd1_o (rs1_val),
    .rd2_o (rs2_val)
  );

  assign pc_o    = pc_q;
  assign alu_o   = alu;
  assign wdata_o = rs2_val;

endmodule

// File: rtl/ucsbece154b_mem.sv
// Word memory with address decode: combinational reads on both ports, optional posedge
// write on port a. Contents are not reset; the harness preloads DATA[] before running.
module ucsbece154b_mem
  import ucsbece154b_pkg::*;
#(
  parameter logic [31:0] Base        = DataBaseDefault,
  parameter int unsigned Words       = 64,
  parameter bit          WriteEn     = 1'b1,
  parameter bit          StrictAlign = 1'b0,
  parameter logic [31:0] Fill        = 32'h0
) (
  input logic          clk_i,
  ucsbece154b_if.slave bus
);

  localparam int unsigned IdxW = (Words > 1) ? $clog2(Words) : 1;

  logic [31:0] DATA [Words];

  function automatic logic hit(input logic [31:0] a);
    logic [31:0] off;
    off = a - Base;
    return (off < (32'(Words) << 2)) && (!StrictAlign || (off[1:0] == 2'b00));
  endfunction

  function automatic logic [IdxW-1:0] idx(input logic [31:0] a);
    logic [31:0] off;
    off = a - Base;
    return off[IdxW+1:2];
  endfunction

  always_comb begin
    bus.rdata   = Fill;
    bus.rdata_b = Fill;
    if (hit(bus.addr))   bus.rdata   = DATA[idx(bus.addr)];
    if (hit(bus.addr_b)) bus.rdata_b = DATA[idx(bus.addr_b)];
  end

  // Same-cycle read of the written word still sees the old value.
  always_ff @(posedge clk_i) begin
    if (WriteEn && bus.we && hit(bus.addr)) begin
      DATA[idx(bus.addr)] <= bus.wdata;
    end
  end

endmodule

// File: rtl/ucsbece154b_rf.sv
// 32 x 32 register file, async active-low clear; x0 hardwired to zero. ABI-named wires
// double as the read view so every name is a live net.
module ucsbece154b_rf (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [4:0]  rd_i,
  input  logic        we_i,
  input  logic [31:0] wd_i,
  output logic [31:0] rd1_o,
  output logic [31:0] rd2_o
);

  logic [31:0] rf_q [32];
  logic [31:0] rf_d [32];

  logic [31:0] zero, ra, sp, gp, tp, t0, t1, t2, s0, s1;
  logic [31:0] a0, a1, a2, a3, a4, a5, a6, a7;
  logic [31:0] s2, s3, s4, s5, s6, s7, s8, s9, s10, s11, t3, t4, t5, t6;
  logic [31:0] view [32];

  always_comb begin
    rf_d = rf_q;
    if (we_i && (rd_i != 5'd0)) rf_d[rd_i] = wd_i;
    rf_d[0] = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      rf_q <= rf_d;
    end
  end

  assign zero = '0;
  assign ra   = rf_q[1];
  assign sp   = rf_q[2];
  assign gp   = rf_q[3];
  assign tp   = rf_q[4];
  assign t0   = rf_q[5];
  assign t1   = rf_q[6];
  assign t2   = rf_q[7];
  assign s0   = rf_q[8];
  assign s1   = rf_q[9];
  assign a0   = rf_q[10];
  assign a1   = rf_q[11];
  assign a2   = rf_q[12];
  assign a3   = rf_q[13];
  assign a4   = rf_q[14];
  assign a5   = rf_q[15];
  assign a6   = rf_q[16];
  assign a7   = rf_q[17];
  assign s2   = rf_q[18];
  assign s3   = rf_q[19];
  assign s4   = rf_q[20];
  assign s5   = rf_q[21];
  assign s6   = rf_q[22];
  assign s7   = rf_q[23];
  assign s8   = rf_q[24];
  assign s9   = rf_q[25];
  assign s10  = rf_q[26];
  assign s11  = rf_q[27];
  assign t3   = rf_q[28];
  assign t4   = rf_q[29];
  assign t5   = rf_q[30];
  assign t6   = rf_q[31];

  assign view = '{zero, ra, sp, gp, tp, t0, t1, t2, s0, s1, a0, a1, a2, a3, a4, a5,
                  a6, a7, s2, s3, s4, s5, s6, s7, s8, s9, s10, s11, t3, t4, t5, t6};

  assign rd1_o = view[rs1_i];
  assign rd2_o = view[rs2_i];

endmodule

// File: rtl/ucsbece154b_riscv.sv
// RV32I core: decode plus datapath, talking to flat instruction and data buses.
module ucsbece154b_riscv
  import ucsbece154b_pkg::*;
#(
  parameter logic [31:0] ResetPc = TextBaseDefault
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  ucsbece154b_if.master imem,
  ucsbece154b_if.master dmem
);

  logic [31:0] instr, pc, alu, wdata;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  ctrl_t       ctrl;
  logic        unused_slot_b;

  assign instr         = imem.rdata;
  assign opcode        = instr[6:0];
  assign funct3        = instr[14:12];
  assign unused_slot_b = ^{imem.rdata_b, dmem.rdata_b};

  always_comb begin
    ctrl = '0;
    case (opcode)
      OpLui: begin
        ctrl.reg_we = 1'b1; ctrl.alu_src_imm = 1'b1;
        ctrl.alu_op = AluPassB; ctrl.imm_sel = ImmU;
      end
      OpAuipc: begin
        ctrl.reg_we = 1'b1; ctrl.alu_src_imm = 1'b1; ctrl.alu_a_pc = 1'b1;
        ctrl.imm_sel = ImmU;
      end
      OpJal: begin
        ctrl.reg_we = 1'b1; ctrl.jump = 1'b1; ctrl.wb_sel = WbPc4; ctrl.imm_sel = ImmJ;
      end
      OpJalr: begin
        ctrl.reg_we = 1'b1; ctrl.jalr = 1'b1; ctrl.alu_src_imm = 1'b1;
        ctrl.wb_sel = WbPc4;
      end
      OpBranch: begin
        ctrl.branch = 1'b1; ctrl.imm_sel = ImmB;
      end
      OpLoad: begin
        ctrl.reg_we = 1'b1; ctrl.alu_src_imm = 1'b1; ctrl.wb_sel = WbMem;
      end
      OpStore: begin
        ctrl.mem_we = 1'b1; ctrl.alu_src_imm = 1'b1; ctrl.imm_sel = ImmS;
      end
      OpImm: begin
        // bit 30 is part of the immediate except for SRAI
        ctrl.reg_we = 1'b1; ctrl.alu_src_imm = 1'b1;
        ctrl.alu_op = alu_fn(funct3, instr[30] && (funct3 == 3'b101));
      end
      OpReg: begin
        ctrl.reg_we = 1'b1;
        ctrl.alu_op = alu_fn(funct3, instr[30]);
      end
      default: ctrl = '0;
    endcase
  end

  ucsbece154b_datapath #(
    .ResetPc(ResetPc)
  ) dp (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .instr_i(instr),
    .ctrl_i (ctrl),
    .rdata_i(dmem.rdata),
    .pc_o   (pc),
    .alu_o  (alu),
    .wdata_o(wdata)
  );

  assign imem.addr   = pc;
  assign imem.addr_b = pc + 32'd4;
  assign imem.wdata  = '0;
  assign imem.we     = 1'b0;

  // Gate with reset so a store in flight when reset asserts never lands.
  assign dmem.addr   = alu;
  assign dmem.addr_b = alu;
  assign dmem.wdata  = wdata;
  assign dmem.we     = ctrl.mem_we && rst_ni;

endmodule

// File: rtl/ucsbece154b_top_soc.sv
// SoC top: RV32I core plus read-only instruction memory and word-addressed data RAM.
module ucsbece154b_top_soc
  import ucsbece154b_pkg::*;
#(
  parameter logic [31:0] TEXT_BASE  = TextBaseDefault,
  parameter int unsigned TEXT_WORDS = 64,
  parameter logic [31:0] DATA_BASE  = DataBaseDefault,
  parameter int unsigned DATA_WORDS = 64
) (
  input logic clk,
  input logic reset
);

  ucsbece154b_if ibus ();
  ucsbece154b_if dbus ();

  ucsbece154b_riscv #(
    .ResetPc(TEXT_BASE)
  ) riscv (
    .clk_i (clk),
    .rst_ni(reset),
    .imem  (ibus),
    .dmem  (dbus)
  );

  ucsbece154b_mem #(
    .Base       (TEXT_BASE),
    .Words      (TEXT_WORDS),
    .WriteEn    (1'b0),
    .StrictAlign(1'b1),
    .Fill       (NopInstr)
  ) imem (
    .clk_i(clk),
    .bus  (ibus)
  );

  ucsbece154b_mem #(
    .Base       (DATA_BASE),
    .Words      (DATA_WORDS),
    .WriteEn    (1'b1),
    .StrictAlign(1'b0),
    .Fill       (32'h0)
  ) dmem (
    .clk_i(clk),
    .bus  (dbus)
  );

endmodule

// File: tb/tb_ucsbece154b_top_soc.sv
// Directed programs for the SoC; stores are scoreboarded off the data bus, architectural
// state is checked hierarchically after each program.
module tb_ucsbece154b_top_soc;
  import ucsbece154b_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  ucsbece154b_top_soc dut (
    .clk  (clk),
    .reset(reset)
  );

  ucsbece154b_if mon_bus ();
  assign mon_bus.addr    = dut.dbus.addr;
  assign mon_bus.addr_b  = dut.dbus.addr_b;
  assign mon_bus.wdata   = dut.dbus.wdata;
  assign mon_bus.we      = dut.dbus.we;
  assign mon_bus.rdata   = dut.dbus.rdata;
  assign mon_bus.rdata_b = dut.dbus.rdata_b;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } store_t;

  store_t      exp_q [$];
  logic [31:0] img [$];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Store monitor: every write cycle on the data bus must match the next expected store.
  always @(negedge clk) begin
    store_t e;
    if (mon_bus.we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL store_unexpected: got %h <- %h, expected no store",
                 mon_bus.addr, mon_bus.wdata);
      end else begin
        e = exp_q.pop_front();
        check("store_addr", mon_bus.addr, e.addr);
        check("store_data", mon_bus.wdata, e.data);
      end
    end
  end

  task automatic load_text();
    for (int i = 0; i < 64; i++) begin
      dut.imem.DATA[i] = (i < img.size()) ? img[i] : NopInstr;
    end
  endtask

  task automatic enter_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic leave_reset_and_run(input int cycles);
    @(negedge clk);
    reset = 1'b1;
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    #1 reset = 1'b0;
    for (int i = 0; i < 64; i++) dut.dmem.DATA[i] = 32'h0;

    // addi a0,zero,5 ; addi a1,a0,7
    img = '{32'h0050_0513, 32'h0075_0593};
    load_text();
    repeat (3) @(negedge clk);
    check("reset_pc_held", dut.riscv.dp.pc_q, 32'h0001_0000);
    reset = 1'b1;
    #1;
    check("reset_pc", dut.riscv.dp.pc_q, 32'h0001_0000);
    check("reset_zero", dut.riscv.dp.rf.zero, 32'h0);
    check("reset_ra", dut.riscv.dp.rf.ra, 32'h0);
    check("reset_a0", dut.riscv.dp.rf.a0, 32'h0);
    check("reset_s0", dut.riscv.dp.rf.s0, 32'h0);
    check("reset_t6", dut.riscv.dp.rf.t6, 32'h0);
    repeat (20) @(negedge clk);
    check("addi_a0", dut.riscv.dp.rf.a0, 32'd5);
    check("addi_a1", dut.riscv.dp.rf.a1, 32'd12);
    check("addi_zero", dut.riscv.dp.rf.zero, 32'h0);
    check("addi_pc", dut.riscv.dp.pc_q, 32'h0001_0050);

    // lui t0,0x10000 ; lui t1,0xBEEF0 ; srli t1,t1,4 ; sw t1,0x70(t0)
    enter_reset();
    img = '{32'h1000_02B7, 32'hBEEF_0337, 32'h0043_5313, 32'h0662_A823};
    load_text();
    exp_q.push_back('{addr: 32'h1000_0070, data: 32'h0BEE_F000});
    leave_reset_and_run(20);
    check("sw_t0", dut.riscv.dp.rf.t0, 32'h1000_0000);
    check("sw_t1", dut.riscv.dp.rf.t1, 32'h0BEE_F000);
    check("sw_dmem28", dut.dmem.DATA[28], 32'h0BEE_F000);

    // lui t0,0x10000 ; lw a2,0(t0)
    enter_reset();
    img = '{32'h1000_02B7, 32'h0002_A603};
    load_text();
    dut.dmem.DATA[0] = 32'hCAFE_0001;
    leave_reset_and_run(20);
    check("lw_a2", dut.riscv.dp.rf.a2, 32'hCAFE_0001);

    // loop: addi s0,s0,1 ; j loop -- then reset in the middle of a cycle
    enter_reset();
    img = '{32'h0014_0413, 32'hFFDF_F06F};
    load_text();
    leave_reset_and_run(10);
    check("loop_s0", dut.riscv.dp.rf.s0, 32'd5);
    check("loop_pc", dut.riscv.dp.pc_q, 32'h0001_0000);
    #2 reset = 1'b0;
    #1;
    check("midreset_s0", dut.riscv.dp.rf.s0, 32'h0);
    check("midreset_pc", dut.riscv.dp.pc_q, 32'h0001_0000);
    leave_reset_and_run(6);
    check("restart_s0", dut.riscv.dp.rf.s0, 32'd3);

    // lui t0,0x20000 ; addi t1,zero,0x55 ; sw t1,0(t0) ; then fetch runs off the end
    enter_reset();
    img = '{32'h2000_02B7, 32'h0550_0313, 32'h0062_A023};
    load_text();
    exp_q.push_back('{addr: 32'h2000_0000, data: 32'h0000_0055});
    leave_reset_and_run(80);
    check("oob_dmem0", dut.dmem.DATA[0], 32'hCAFE_0001);
    check("oob_dmem28", dut.dmem.DATA[28], 32'h0BEE_F000);
    check("oob_t0", dut.riscv.dp.rf.t0, 32'h2000_0000);
    check("oob_t1", dut.riscv.dp.rf.t1, 32'h0000_0055);
    check("oob_pc", dut.riscv.dp.pc_q, 32'h0001_0140);
    check("oob_no_x", {31'b0, $isunknown({dut.riscv.dp.rf.ra, dut.riscv.dp.rf.a0,
                                          dut.riscv.dp.rf.s0, dut.riscv.dp.rf.t6})}, 32'h0);

    check("stores_drained", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
